addr_alu_datapath: RTL and testbench
====================================

# addr_alu_datapath

Address-generation and arithmetic datapath of the microcoded 65C02 core. It combines three parts: the low and high address-bus generators, the program counter, and the 8-bit combinational ALU. All parts are driven each cycle by decoded microcode fields from the control unit. The register file, M register, flag logic and data-output mux stay outside this block.

## Interface
- No parameters.
- clk  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- abl_op  in  5  low-address operation; [4:2] selects the base, [1:0] selects the addend.
- abl_ci  in  1  carry into the low-address adder.
- abh_op  in  3  high-address operation.
- abh_ff  in  1  forces ADH to 0xFF (vector page); overrides abh_op.
- ld_ahl  in  1  capture DB into the AHL holding register.
- ld_pc  in  1  load PC from AD.
- inc_pc  in  1  increment PC.
- DB  in  8  data bus input.
- REG  in  8  register-file read port (R).
- M  in  8  registered data byte.
- alu_op  in  5  ALU operation.
- alu_ci  in  1  ALU carry in.
- alu_si  in  1  ALU shift in.
- AD  out  16  address bus {ADH, ADL}; combinational.
- PCL, PCH  out  8 each  program counter bytes (registered).
- alu_out  out  8  ALU result.
- alu_co  out  1  ALU carry out.
- alu_v  out  1  ALU overflow.
- adjh, adjl  out  1 each  BCD adjust requests.

## Operation
**Internal registers:** ABL, ABH, AHL, PC (16 bits).

**Low address:** ADL = base + addend + abl_ci, truncated to 8 bits; abl_co = bit 8 of the sum.
- Base select abl_op[4:2]: 000 ABL, 001 PCL, 010 AHL, 011 DB, 100 REG, others 0x00.
- Addend select abl_op[1:0]: 00 zero, 01 REG, 10 DB, 11 0xFF.

**High address:** when abh_ff=1, ADH = 0xFF. Otherwise abh_op selects:
- 000 ABH
- 001 DB
- 010 ABH + abl_co
- 011 DB + abl_co
- 100 PCH
- 101 0x00
- 110 0x01
- 111 ABH + 1

All high-address sums are 8-bit and wrap (0xFF + 1 = 0x00).

**Program counter:**
- src = ld_pc ? AD : PC.
- PC <= src + inc_pc, 16-bit, wrapping 0xFFFF to 0x0000.
- The carry from PCL into PCH occurs only when inc_pc=1 and src[7:0]=0xFF.

**ALU:** purely combinational. X = alu_op[0] ? M : R, with R = REG. alu_op[4:2] selects:
- 000 R|M
- 001 R&M
- 010 R^M
- 011 R+M+CI
- 100 R+~M+CI
- 101 {X[6:0],SI}, with CO = X[7]
- 110 {SI,X[7:1]}, with CO = X[0]
- 111 X (pass)

For logic and pass ops, CO=0 and V=0. For 011/100, V is two's-complement signed overflow of the sum.

**BCD adjust:** valid only for 011/100 with alu_op[1]=1; otherwise adjh = adjl = 0. alu_op[0] is ignored for 000–100.
- Add: adjl = (R[3:0] + M[3:0] + CI) > 9; adjh = 9-bit binary sum > 0x99.
- Subtract: adjl = no carry out of the low nibble; adjh = ~CO.

## Timing
- AD, alu_out, alu_co, alu_v, adjh and adjl are combinational from the current inputs and registers, with zero latency.
- Every clock with RST=0: ABL <= ADL and ABH <= ADH, unconditionally. Op "hold" (000) therefore repeats the previous address.
- AHL <= DB when ld_ahl=1. Ops that read AHL in the same cycle see the old value.
- ld_pc samples the same-cycle combinational AD. The new PC is visible on PCL/PCH in the next cycle.
- Reset: on a clock with RST=1, ABL, ABH, AHL and PC are cleared to 0x00/0x0000. Reset overrides ld_ahl, ld_pc and inc_pc. With all ops 0 after reset, AD=0x0000, PCL=PCH=0x00.
- Reset asserted mid-operation discards partial address or PC state on that edge. Combinational outputs keep following their inputs during reset.

## Test plan
- **Reset:** drive RST for 1 clock with inc_pc=1, ld_pc=1 -> PCL=PCH=0x00; with ops 0, AD=0x0000.
- **Sequential fetch:** PC=0x12FF, abl_op=001_00, abh_op=100, inc_pc=1 -> AD=0x12FF this cycle; PC=0x1300 next cycle.
- **Indexed page cross:** AHL=0xF0 (load via ld_ahl, DB=0xF0), abl_op=010_01, REG=0x20, DB=0x34, abh_op=011 -> ADL=0x10, abl_co=1, AD=0x3510.
- **Vector and stack pages:**
  - abh_ff=1, abl_op=100_00, REG=0xFC -> AD=0xFFFC.
  - abh_op=110, REG=0xFF, abl_op=100_11 -> AD=0x01FE.
- **Jump:** abl_op=010_00, abh_op=001, DB=0xAB, AHL=0xCD, ld_pc=1, inc_pc=0 -> PC=0xABCD next cycle.
- **ALU:**
  - add 0x50+0x50, CI=0 -> 0xA0, V=1, CO=0; with BCD on, adjh=1, adjl=0.
  - sub 0x10-0x01, CI=1 -> 0x0F, CO=1; with BCD on, adjl=1.
  - ROL R=0x80, SI=1 -> 0x01, CO=1.

Source files
------------

// File: rtl/addr_alu_datapath.sv
// Address generators, program counter and 8-bit ALU of the microcoded 65C02 core.
// Address and ALU results are combinational; ABL/ABH/AHL/PC update on the rising clock.
module addr_alu_datapath (
  input  logic        clk,
  input  logic        RST,
  input  logic [4:0]  abl_op,
  input  logic        abl_ci,
  input  logic [2:0]  abh_op,
  input  logic        abh_ff,
  input  logic        ld_ahl,
  input  logic        ld_pc,
  input  logic        inc_pc,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  input  logic [7:0]  M,
  input  logic [4:0]  alu_op,
  input  logic        alu_ci,
  input  logic        alu_si,
  output logic [15:0] AD,
  output logic [7:0]  PCL,
  output logic [7:0]  PCH,
  output logic [7:0]  alu_out,
  output logic        alu_co,
  output logic        alu_v,
  output logic        adjh,
  output logic        adjl
);

  logic [7:0]  abl_reg, abh_reg, ahl_reg;
  logic [15:0] pc_reg, pc_next;
  logic [7:0]  adl_base, adl_addend, adh;
  logic [8:0]  adl_sum;
  logic        abl_co;

  always_comb begin
    adl_base = 8'h00;
    case (abl_op[4:2])
      3'b000:  adl_base = abl_reg;
      3'b001:  adl_base = pc_reg[7:0];
      3'b010:  adl_base = ahl_reg;
      3'b011:  adl_base = DB;
      3'b100:  adl_base = REG;
      default: adl_base = 8'h00;
    endcase
    adl_addend = 8'h00;
    case (abl_op[1:0])
      2'b00:   adl_addend = 8'h00;
      2'b01:   adl_addend = REG;
      2'b10:   adl_addend = DB;
      default: adl_addend = 8'hFF;
    endcase
    adl_sum = {1'b0, adl_base} + {1'b0, adl_addend} + {8'h00, abl_ci};
    abl_co  = adl_sum[8];
  end

  // Vector-page force wins over any high-address operation.
  always_comb begin
    adh = 8'h00;
    if (abh_ff) begin
      adh = 8'hFF;
    end else begin
      case (abh_op)
        3'b000:  adh = abh_reg;
        3'b001:  adh = DB;
        3'b010:  adh = abh_reg + {7'b0, abl_co};
        3'b011:  adh = DB + {7'b0, abl_co};
        3'b100:  adh = pc_reg[15:8];
        3'b101:  adh = 8'h00;
        3'b110:  adh = 8'h01;
        default: adh = abh_reg + 8'h01;
      endcase
    end
  end

  assign AD      = {adh, adl_sum[7:0]};
  assign pc_next = (ld_pc ? AD : pc_reg) + {15'b0, inc_pc};
  assign PCL     = pc_reg[7:0];
  assign PCH     = pc_reg[15:8];

  always_ff @(posedge clk) begin
    if (RST) begin
      abl_reg <= 8'h00;
      abh_reg <= 8'h00;
      ahl_reg <= 8'h00;
      pc_reg  <= 16'h0000;
    end else begin
      abl_reg <= adl_sum[7:0];
      abh_reg <= adh;
      if (ld_ahl) ahl_reg <= DB;
      pc_reg  <= pc_next;
    end
  end

  logic [7:0] alu_x, m_eff;
  logic [8:0] alu_sum;
  logic [4:0] nib_sum;

  // Subtraction reuses the adder with the M operand inverted.
  always_comb begin
    alu_x   = alu_op[0] ? M : REG;
    m_eff   = (alu_op[4:2] == 3'b100) ? ~M : M;
    alu_sum = {1'b0, REG} + {1'b0, m_eff} + {8'h00, alu_ci};
    nib_sum = {1'b0, REG[3:0]} + {1'b0, m_eff[3:0]} + {4'h0, alu_ci};
    alu_out = 8'h00;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    adjh    = 1'b0;
    adjl    = 1'b0;
    case (alu_op[4:2])
      3'b000: alu_out = REG | M;
      3'b001: alu_out = REG & M;
      3'b010: alu_out = REG ^ M;
      3'b011, 3'b100: begin
        alu_out = alu_sum[7:0];
        alu_co  = alu_sum[8];
        alu_v   = (REG[7] == m_eff[7]) && (alu_sum[7] != REG[7]);
        if (alu_op[1]) begin
          if (alu_op[4:2] == 3'b011) begin
            adjl = (nib_sum > 5'd9);
            adjh = (alu_sum > 9'h099);
          end else begin
            adjl = ~nib_sum[4];
            adjh = ~alu_sum[8];
          end
        end
      end
      3'b101: begin
        alu_out = {alu_x[6:0], alu_si};
        alu_co  = alu_x[7];
      end
      3'b110: begin
        alu_out = {alu_si, alu_x[7:1]};
        alu_co  = alu_x[0];
      end
      default: alu_out = alu_x;
    endcase
  end

endmodule

// File: tb/tb_addr_alu_datapath.sv
// Self-checking bench for addr_alu_datapath: directed scenarios plus randomized
// address and ALU traffic against an arithmetic reference model.
module tb_addr_alu_datapath;

  logic        clk;
  logic        RST;
  logic [4:0]  abl_op;
  logic        abl_ci;
  logic [2:0]  abh_op;
  logic        abh_ff, ld_ahl, ld_pc, inc_pc;
  logic [7:0]  DB, REG, M;
  logic [4:0]  alu_op;
  logic        alu_ci, alu_si;
  logic [15:0] AD;
  logic [7:0]  PCL, PCH, alu_out;
  logic        alu_co, alu_v, adjh, adjl;

  int vectors = 0;
  int errors  = 0;
  int m_abl = 0, m_abh = 0, m_ahl = 0, m_pc = 0;

  addr_alu_datapath dut (
    .clk(clk), .RST(RST), .abl_op(abl_op), .abl_ci(abl_ci), .abh_op(abh_op),
    .abh_ff(abh_ff), .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc),
    .DB(DB), .REG(REG), .M(M), .alu_op(alu_op), .alu_ci(alu_ci), .alu_si(alu_si),
    .AD(AD), .PCL(PCL), .PCH(PCH), .alu_out(alu_out), .alu_co(alu_co),
    .alu_v(alu_v), .adjh(adjh), .adjl(adjl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected address from the current inputs and model registers.
  function automatic int model_ad();
    int base, add, sum, co, lo, hi;
    case (int'(abl_op) / 4)
      0: base = m_abl;
      1: base = m_pc % 256;
      2: base = m_ahl;
      3: base = int'(DB);
      4: base = int'(REG);
      default: base = 0;
    endcase
    case (int'(abl_op) % 4)
      0: add = 0;
      1: add = int'(REG);
      2: add = int'(DB);
      default: add = 255;
    endcase
    sum = base + add + int'(abl_ci);
    co  = sum / 256;
    lo  = sum % 256;
    if (abh_ff) hi = 255;
    else begin
      case (int'(abh_op))
        0: hi = m_abh;
        1: hi = int'(DB);
        2: hi = (m_abh + co) % 256;
        3: hi = (int'(DB) + co) % 256;
        4: hi = m_pc / 256;
        5: hi = 0;
        6: hi = 1;
        default: hi = (m_abh + 1) % 256;
      endcase
    end
    return hi * 256 + lo;
  endfunction

  // Returns {adjl, adjh, v, co, result[7:0]} as an int.
  function automatic int model_alu();
    int r, m, x, ci, si, op, res, co, v, ah, al, sr, sm, ss, s;
    r = int'(REG); m = int'(M); ci = int'(alu_ci); si = int'(alu_si);
    op = int'(alu_op);
    x = (op % 2 == 1) ? m : r;
    res = 0; co = 0; v = 0; ah = 0; al = 0;
    sr = (r > 127) ? r - 256 : r;
    sm = (m > 127) ? m - 256 : m;
    case (op / 4)
      0: res = r | m;
      1: res = r & m;
      2: res = r ^ m;
      3: begin
        s = r + m + ci; res = s % 256; co = s / 256;
        ss = sr + sm + ci; v = (ss > 127 || ss < -128) ? 1 : 0;
        if ((op / 2) % 2 == 1) begin
          al = ((r % 16) + (m % 16) + ci > 9) ? 1 : 0;
          ah = (s > 153) ? 1 : 0;
        end
      end
      4: begin
        s = r - m - 1 + ci;
        co = (s >= 0) ? 1 : 0;
        res = (s + 256) % 256;
        ss = sr - sm - 1 + ci; v = (ss > 127 || ss < -128) ? 1 : 0;
        if ((op / 2) % 2 == 1) begin
          al = ((r % 16) - (m % 16) - 1 + ci < 0) ? 1 : 0;
          ah = 1 - co;
        end
      end
      5: begin res = (x * 2 + si) % 256; co = x / 128; end
      6: begin res = si * 128 + x / 2; co = x % 2; end
      default: res = x;
    endcase
    return res + co * 256 + v * 512 + ah * 1024 + al * 2048;
  endfunction

  task automatic clk_step();
    int ad;
    ad = model_ad();
    @(posedge clk); #1;
    if (RST) begin
      m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
    end else begin
      m_abl = ad % 256;
      m_abh = ad / 256;
      if (ld_ahl) m_ahl = int'(DB);
      m_pc = ((ld_pc ? ad : m_pc) + int'(inc_pc)) % 65536;
    end
  endtask

  task automatic idle_inputs();
    abl_op = 5'd0; abl_ci = 1'b0; abh_op = 3'd0; abh_ff = 1'b0;
    ld_ahl = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1; inc_pc = 1'b1; ld_pc = 1'b1; DB = 8'h5A;
    clk_step();
    RST = 1'b0; idle_inputs(); #1;
    vectors++;
    if ({PCH, PCL} !== 16'h0000) begin
      errors++; $display("FAIL reset_pc got %h want 0000", {PCH, PCL});
    end
    vectors++;
    if (AD !== 16'h0000) begin
      errors++; $display("FAIL reset_ad got %h want 0000", AD);
    end
    $display("reset: AD=%h PC=%h", AD, {PCH, PCL});
  endtask

  task automatic test_fetch();
    abl_op = 5'b100_00; REG = 8'hFF; abh_op = 3'b001; DB = 8'h12; ld_pc = 1'b1;
    clk_step();
    idle_inputs();
    abl_op = 5'b001_00; abh_op = 3'b100; inc_pc = 1'b1; #1;
    vectors++;
    if (AD !== 16'h12FF) begin
      errors++; $display("FAIL fetch_ad got %h want 12ff", AD);
    end
    clk_step();
    inc_pc = 1'b0;
    vectors++;
    if ({PCH, PCL} !== 16'h1300) begin
      errors++; $display("FAIL fetch_pc_carry got %h want 1300", {PCH, PCL});
    end
    $display("fetch: PC=%h", {PCH, PCL});
  endtask

  task automatic test_page_cross();
    idle_inputs();
    ld_ahl = 1'b1; DB = 8'hF0;
    clk_step();
    ld_ahl = 1'b0; abl_op = 5'b010_01; REG = 8'h20; DB = 8'h34; abh_op = 3'b011; #1;
    vectors++;
    if (AD !== 16'h3510) begin
      errors++; $display("FAIL page_cross_ad got %h want 3510", AD);
    end
    clk_step();
    abl_op = 5'b000_00; abh_op = 3'b000; #1;
    vectors++;
    if (AD !== 16'h3510) begin
      errors++; $display("FAIL hold_ad got %h want 3510", AD);
    end
    $display("page_cross: AD=%h", AD);
  endtask

  task automatic test_vectors();
    idle_inputs();
    abh_ff = 1'b1; abh_op = 3'b101; abl_op = 5'b100_00; REG = 8'hFC; #1;
    vectors++;
    if (AD !== 16'hFFFC) begin
      errors++; $display("FAIL vector_ad got %h want fffc", AD);
    end
    clk_step();
    idle_inputs();
    abh_op = 3'b111; #1;
    vectors++;
    if (AD !== 16'h00FC) begin
      errors++; $display("FAIL abh_inc_wrap got %h want 00fc", AD);
    end
    abh_op = 3'b110; REG = 8'hFF; abl_op = 5'b100_11; #1;
    vectors++;
    if (AD !== 16'h01FE) begin
      errors++; $display("FAIL stack_ad got %h want 01fe", AD);
    end
    clk_step();
    $display("vectors: stack AD=01fe checked");
  endtask

  task automatic test_jump();
    idle_inputs();
    ld_ahl = 1'b1; DB = 8'hCD;
    clk_step();
    ld_ahl = 1'b0; abl_op = 5'b010_00; abh_op = 3'b001; DB = 8'hAB; ld_pc = 1'b1; #1;
    vectors++;
    if (AD !== 16'hABCD) begin
      errors++; $display("FAIL jump_ad got %h want abcd", AD);
    end
    clk_step();
    idle_inputs();
    vectors++;
    if ({PCH, PCL} !== 16'hABCD) begin
      errors++; $display("FAIL jump_pc got %h want abcd", {PCH, PCL});
    end
    abh_ff = 1'b1; abl_op = 5'b101_11; ld_pc = 1'b1; inc_pc = 1'b1;
    clk_step();
    idle_inputs();
    vectors++;
    if ({PCH, PCL} !== 16'h0000) begin
      errors++; $display("FAIL pc_wrap got %h want 0000", {PCH, PCL});
    end
    $display("jump: PC=%h", {PCH, PCL});
  endtask

  task automatic test_alu_directed();
    alu_op = 5'b011_10; REG = 8'h50; M = 8'h50; alu_ci = 1'b0; alu_si = 1'b0; #1;
    vectors++;
    if ({adjl, adjh, alu_v, alu_co, alu_out} !== {4'b0110, 8'hA0}) begin
      errors++; $display("FAIL alu_add_bcd got %b want 011010100000", {adjl, adjh, alu_v, alu_co, alu_out});
    end
    alu_op = 5'b100_10; REG = 8'h10; M = 8'h01; alu_ci = 1'b1; #1;
    vectors++;
    if ({adjl, adjh, alu_v, alu_co, alu_out} !== {4'b1001, 8'h0F}) begin
      errors++; $display("FAIL alu_sub_bcd got %b want 100100001111", {adjl, adjh, alu_v, alu_co, alu_out});
    end
    alu_op = 5'b101_00; REG = 8'h80; alu_si = 1'b1; #1;
    vectors++;
    if ({alu_co, alu_out} !== 9'h101) begin
      errors++; $display("FAIL alu_rol got %h want 101", {alu_co, alu_out});
    end
    $display("alu_directed: ROL out=%h co=%b", alu_out, alu_co);
  endtask

  task automatic test_alu_random();
    int exp_v, got_v;
    for (int i = 0; i < 200; i++) begin
      alu_op = 5'($urandom); REG = 8'($urandom); M = 8'($urandom);
      alu_ci = 1'($urandom); alu_si = 1'($urandom); #1;
      exp_v = model_alu();
      got_v = int'({adjl, adjh, alu_v, alu_co, alu_out});
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL alu_rand op=%b r=%h m=%h ci=%b got %h want %h",
                 alu_op, REG, M, alu_ci, got_v, exp_v);
      end
    end
    $display("alu_random: 200 vectors");
  endtask

  task automatic test_back_to_back();
    int exp_ad;
    for (int i = 0; i < 300; i++) begin
      RST = ($urandom_range(0, 19) == 0);
      abl_op = 5'($urandom); abl_ci = 1'($urandom); abh_op = 3'($urandom);
      abh_ff = ($urandom_range(0, 7) == 0); ld_ahl = 1'($urandom);
      ld_pc = ($urandom_range(0, 3) == 0); inc_pc = 1'($urandom);
      DB = 8'($urandom); REG = 8'($urandom); #1;
      exp_ad = model_ad();
      vectors++;
      if (int'(AD) !== exp_ad) begin
        errors++; $display("FAIL rand_ad cycle=%0d got %h want %h", i, AD, exp_ad);
      end
      clk_step();
      vectors++;
      if (int'({PCH, PCL}) !== m_pc) begin
        errors++; $display("FAIL rand_pc cycle=%0d got %h want %h", i, {PCH, PCL}, m_pc);
      end
    end
    RST = 1'b0;
    $display("back_to_back: 300 cycles");
  endtask

  initial begin
    RST = 1'b1; idle_inputs();
    DB = 8'h00; REG = 8'h00; M = 8'h00;
    alu_op = 5'd0; alu_ci = 1'b0; alu_si = 1'b0;
    #1;
    clk_step();
    clk_step();
    test_reset();
    test_fetch();
    test_page_cross();
    test_vectors();
    test_jump();
    test_alu_directed();
    test_alu_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
